// File: rtl/execcmd_burst_if.sv
// rtl/execcmd_burst_if.sv - register bus with a ready handshake, shared by the executor and the register fabric
interface execcmd_burst_if #(
  parameter int RAW = 14,
  parameter int DW  = 32
) ();
  logic [RAW-1:0] reg_addr;
  logic           reg_rd;
  logic           reg_wr;
  logic           reg_ready;
  logic [DW-1:0]  reg_writedata;
  logic [DW-1:0]  reg_readdata;

  modport master (
    output reg_addr, reg_rd, reg_wr, reg_writedata,
    input  reg_ready, reg_readdata
  );

  modport slave (
    input  reg_addr, reg_rd, reg_wr, reg_writedata,
    output reg_ready, reg_readdata
  );
endinterface

// File: rtl/execcmd_burst.sv
// rtl/execcmd_burst.sv - command-list executor: reads, writes and burst reads on the register bus, results to the output RAM
// Optional bus timeout (error code 3) is built when EXECCMD_TIMEOUT_EN is defined.
module execcmd_burst #(
  parameter int AW      = 10,
  parameter int RAW     = 14,
  parameter int DW      = 32,
  parameter int OUT_MAX = 800,
  parameter int TO_W    = 12
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] inram_address,
  output logic          inram_re,
  input  logic [15:0]   inram_q,
  output logic [AW-1:0] outram_address,
  output logic          outram_we,
  output logic [15:0]   outram_d,
  execcmd_burst_if.master bus,
  input  logic          start_exec,
  output logic          busy,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] out_len
);
  localparam int NW = DW / 16;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = AW + 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_BURST = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  if (TO_W < 1 || RAW > 14 || RAW < 1 || (DW % 16) != 0) begin : g_bad_params
  end

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_FETCH, S_DECODE, S_WDATA,
    S_WR_REQ, S_CNT, S_RD_REQ, S_STORE, S_DONE
  } state_t;

  state_t state, state_nx;

  // idx/out_ptr carry one extra bit so "one past the end" is representable without wrapping
  logic [PW-1:0]  idx;
  logic [PW-1:0]  out_ptr;
  logic [15:0]    in_len;
  logic [15:0]    remain;
  logic [CW-1:0]  wcnt;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;
  logic [RAW-1:0] addr;
  logic [1:0]     code;

  logic       have_word;
  logic       out_full;
  logic       last_word;
  logic       len_short;
  logic       len_big;
  logic       to_hit;
  logic [1:0] op;

  assign have_word = 32'(idx) < 32'(in_len);
  assign out_full  = 32'(out_ptr) >= 32'(OUT_MAX);
  assign last_word = (wcnt == CW'(NW - 1));
  assign len_short = (inram_q <= 16'd1);
  assign len_big   = 32'(inram_q) > (32'd1 << AW);
  assign op        = inram_q[15:14];

  assign inram_address     = idx[AW-1:0];
  assign outram_address    = out_ptr[AW-1:0];
  assign bus.reg_addr      = addr;
  assign bus.reg_writedata = wdata;

`ifdef EXECCMD_TIMEOUT_EN
  logic            req_pend;
  logic [TO_W-1:0] to_cnt;

  assign req_pend = (state == S_RD_REQ) || (state == S_WR_REQ);

  // Starts at 1 so the request is held for exactly 2**TO_W-1 cycles before giving up
  always_ff @(posedge clk) begin
    if (rst || !req_pend || bus.reg_ready) to_cnt <= TO_W'(1);
    else                                   to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = req_pend && !bus.reg_ready && (&to_cnt);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start_exec) state_nx = S_LEN;
      S_LEN:    state_nx = (len_short || len_big) ? S_DONE : S_FETCH;
      S_FETCH:  state_nx = have_word ? S_DECODE : S_DONE;
      S_DECODE: begin
        if (out_full) state_nx = S_DONE;
        else begin
          unique case (op)
            OP_WRITE: state_nx = have_word ? S_WDATA : S_DONE;
            OP_READ:  state_nx = S_RD_REQ;
            OP_BURST: state_nx = have_word ? S_CNT : S_DONE;
            default:  state_nx = S_FETCH;
          endcase
        end
      end
      S_WDATA: begin
        if (last_word)       state_nx = S_WR_REQ;
        else if (!have_word) state_nx = S_DONE;
      end
      S_WR_REQ: begin
        if (bus.reg_ready) state_nx = S_FETCH;
        else if (to_hit)   state_nx = S_DONE;
      end
      S_CNT:    state_nx = (inram_q == 16'd0) ? S_FETCH : S_RD_REQ;
      S_RD_REQ: begin
        if (bus.reg_ready) state_nx = S_STORE;
        else if (to_hit)   state_nx = S_DONE;
      end
      S_STORE: begin
        if (out_full)       state_nx = S_DONE;
        else if (last_word) state_nx = (remain == 16'd1) ? S_FETCH : S_RD_REQ;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    inram_re   = 1'b0;
    outram_we  = 1'b0;
    outram_d   = inram_q;
    bus.reg_rd = 1'b0;
    bus.reg_wr = 1'b0;
    unique case (state)
      S_IDLE:   inram_re = start_exec && !rst;
      S_FETCH:  inram_re = have_word;
      S_DECODE: begin
        outram_we = !out_full;
        inram_re  = !out_full && have_word && (op == OP_WRITE || op == OP_BURST);
      end
      S_WDATA:  inram_re = !last_word && have_word;
      S_WR_REQ: bus.reg_wr = 1'b1;
      S_RD_REQ: bus.reg_rd = 1'b1;
      S_STORE: begin
        outram_we = !out_full;
        outram_d  = rdata[DW-1 -: 16];
      end
      default: ;
    endcase
  end

  // Datapath: every inram read issued advances idx, every result word written advances out_ptr
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      out_len  <= '0;
      idx      <= '0;
      out_ptr  <= '0;
      in_len   <= 16'd0;
      remain   <= 16'd0;
      wcnt     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      addr     <= '0;
      code     <= 2'd0;
    end else begin
      unique case (state)
        S_IDLE: if (start_exec) begin
          busy    <= 1'b1;
          idx     <= PW'(1);
          out_ptr <= '0;
          code    <= 2'd0;
        end
        S_LEN: begin
          in_len <= inram_q;
          if (!len_short && len_big) code <= 2'd1;
        end
        S_FETCH: if (have_word) idx <= idx + PW'(1);
        S_DECODE: begin
          if (out_full) code <= 2'd2;
          else begin
            out_ptr <= out_ptr + PW'(1);
            addr    <= inram_q[RAW-1:0];
            remain  <= 16'd1;
            wcnt    <= '0;
            if (op == OP_WRITE || op == OP_BURST) begin
              if (have_word) idx <= idx + PW'(1);
              else           code <= 2'd1;
            end
          end
        end
        S_WDATA: begin
          wdata <= DW'({wdata, inram_q});
          wcnt  <= wcnt + CW'(1);
          if (!last_word) begin
            if (have_word) idx <= idx + PW'(1);
            else           code <= 2'd1;
          end
        end
        S_WR_REQ: if (!bus.reg_ready && to_hit) code <= 2'd3;
        S_CNT:    remain <= inram_q;
        S_RD_REQ: begin
          if (bus.reg_ready) begin
            rdata <= bus.reg_readdata;
            wcnt  <= '0;
          end else if (to_hit) begin
            code <= 2'd3;
          end
        end
        S_STORE: begin
          if (out_full) code <= 2'd2;
          else begin
            out_ptr <= out_ptr + PW'(1);
            rdata   <= rdata << 16;
            wcnt    <= wcnt + CW'(1);
            if (last_word) begin
              remain <= remain - 16'd1;
              addr   <= addr + RAW'(1);
            end
          end
        end
        S_DONE: begin
          busy     <= 1'b0;
          err      <= (code != 2'd0);
          err_code <= code;
          out_len  <= (code == 2'd0) ? out_ptr[AW-1:0] : '0;
          idx      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
